// File: rtl/noc_pkg.sv
// Shared NoC types for the packet requester: flit layout, flit id codes and FSM states.
// Helpers classify flit ids as packet start/end so every block decodes them identically.
package noc_pkg;

  localparam int FLIT_W = 32;
  localparam int LEN_W  = 12;
  localparam int ID_W   = 3;

  localparam logic [ID_W-1:0] ID_HEAD   = 3'b001;
  localparam logic [ID_W-1:0] ID_BODY   = 3'b010;
  localparam logic [ID_W-1:0] ID_TAIL   = 3'b100;
  localparam logic [ID_W-1:0] ID_SINGLE = 3'b101;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_REQ   = 2'd1,
    ST_SEND  = 2'd2,
    ST_STALL = 2'd3
  } req_state_e;

  typedef struct packed {
    logic [ID_W-1:0]             id;
    logic [FLIT_W-ID_W-LEN_W-1:0] payload;
    logic [LEN_W-1:0]            len;
  } flit_t;

  function automatic logic is_start(input logic [ID_W-1:0] id);
    return (id == ID_HEAD) || (id == ID_SINGLE);
  endfunction

  function automatic logic is_end(input logic [ID_W-1:0] id);
    return (id == ID_TAIL) || (id == ID_SINGLE);
  endfunction

endpackage

// File: rtl/packet_requester_if.sv
// Requester port bundle: upstream flit input, arbiter req/grant, crossbar output, status.
// master = the requester itself, slave = its environment (upstream, arbiter, crossbar).
interface packet_requester_if;
  import noc_pkg::*;

  logic              in_valid;
  logic [FLIT_W-1:0] in_flit;
  logic              in_ready;
  logic              grant;
  logic              req;
  logic [ID_W-1:0]   flit_id;
  logic [LEN_W-1:0]  length;
  logic              out_valid;
  logic [FLIT_W-1:0] out_flit;
  logic              out_ready;
  logic              len_err;

  modport master (
    input  in_valid, in_flit, grant, out_ready,
    output in_ready, req, flit_id, length, out_valid, out_flit, len_err
  );

  modport slave (
    output in_valid, in_flit, grant, out_ready,
    input  in_ready, req, flit_id, length, out_valid, out_flit, len_err
  );

endinterface

// File: rtl/requester_fifo.sv
// Generic power-of-two FIFO with a combinational head; written entry is at head right after the edge.
// full/empty come from the registered count only, so a full FIFO never accepts a same-cycle bypass.
module requester_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] push_dat,
  input  logic             pop,
  output logic [WIDTH-1:0] head,
  output logic             full,
  output logic             empty
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      count;
  logic             push_ok;
  logic             pop_ok;

  assign full    = (count == FULL_CNT);
  assign empty   = (count == '0);
  assign push_ok = push && !full;
  assign pop_ok  = pop && !empty;
  assign head    = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem[wr_ptr] <= push_dat;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (pop_ok) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      if (push_ok && !pop_ok) begin
        count <= count + (AW+1)'(1);
      end else if (!push_ok && pop_ok) begin
        count <= count - (AW+1)'(1);
      end
    end
  end

endmodule

// File: rtl/packet_requester.sv
// Buffers flits, requests the arbiter per packet and streams it out under grant; req rises 1 cycle after a header reaches head.
// Upstream stalls via in_ready=!full; grant loss parks the packet in STALL. LEN_CHECK_EN adds the sticky len_err checker.
module packet_requester
  import noc_pkg::*;
#(
  parameter int FIFO_DEPTH = 4
) (
  input  logic                clk,
  input  logic                rst,
  packet_requester_if.master  bus
);

  localparam logic [1:0] IDLE  = ST_IDLE;
  localparam logic [1:0] REQ   = ST_REQ;
  localparam logic [1:0] SEND  = ST_SEND;
  localparam logic [1:0] STALL = ST_STALL;

  logic [1:0]        state;
  logic [1:0]        state_nxt;
  logic [FLIT_W-1:0] head;
  flit_t             head_f;
  logic              full;
  logic              empty;
  logic              push;
  logic              pop;
  logic              xfer;
  logic              discard;
  logic              start_pkt;
  logic [LEN_W-1:0]  len_q;

  assign head_f = head;
  assign push   = bus.in_valid && !full;

  // Non-start flits reaching head outside a packet are orphans; drop one per cycle.
  assign start_pkt = (state == IDLE) && !empty && is_start(head_f.id);
  assign discard   = (state == IDLE) && !empty && !is_start(head_f.id);
  assign xfer      = bus.out_valid && bus.out_ready;
  assign pop       = xfer || discard;

  requester_fifo #(
    .WIDTH (FLIT_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk      (clk),
    .rst      (rst),
    .push     (push),
    .push_dat (bus.in_flit),
    .pop      (pop),
    .head     (head),
    .full     (full),
    .empty    (empty)
  );

  assign bus.in_ready  = !full;
  assign bus.req       = (state != IDLE);
  assign bus.out_valid = (state == SEND) && !empty && bus.grant;
  assign bus.out_flit  = head_f;
  assign bus.length    = len_q;

  always_comb begin
    bus.flit_id = head_f.id;
    case (state)
      IDLE:    bus.flit_id = '0;
      REQ:     bus.flit_id = ID_HEAD;
      default: bus.flit_id = head_f.id;
    endcase
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (start_pkt) begin
          state_nxt = REQ;
        end
      end
      REQ: begin
        if (bus.grant) begin
          state_nxt = SEND;
        end
      end
      SEND: begin
        // Losing grant is a preemption: nothing moves this cycle, resume from STALL.
        if (!bus.grant) begin
          state_nxt = STALL;
        end else if (xfer && is_end(head_f.id)) begin
          state_nxt = IDLE;
        end
      end
      STALL: begin
        if (bus.grant) begin
          state_nxt = SEND;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
      len_q <= '0;
    end else begin
      state <= state_nxt;
      if (start_pkt) begin
        len_q <= (head_f.id == ID_SINGLE) ? LEN_W'(1) : head_f.len;
      end
    end
  end

`ifdef LEN_CHECK_EN
  logic [LEN_W-1:0] xfer_cnt;
  logic [LEN_W-1:0] cnt_inc;
  logic             len_err_q;
  logic             tail_bad;
  logic             early_end;

  assign cnt_inc   = xfer_cnt + LEN_W'(1);
  assign tail_bad  = is_end(head_f.id) && (cnt_inc != len_q);
  assign early_end = !is_end(head_f.id) && (cnt_inc == len_q);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      xfer_cnt  <= '0;
      len_err_q <= 1'b0;
    end else begin
      if (start_pkt) begin
        xfer_cnt <= '0;
      end else if (xfer) begin
        xfer_cnt <= is_end(head_f.id) ? '0 : cnt_inc;
        if (tail_bad || early_end) begin
          len_err_q <= 1'b1;
        end
      end
    end
  end

  assign bus.len_err = len_err_q;
`else
  assign bus.len_err = 1'b0;
`endif

endmodule

// File: tb/tb_packet_requester.sv
// Directed scenarios plus a randomized packet stream scored against an expected-flit queue.
module tb_packet_requester;
  import noc_pkg::*;

  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  packet_requester_if bus ();

  packet_requester #(.FIFO_DEPTH(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

`ifdef LEN_CHECK_EN
  localparam logic EXP_LEN_ERR = 1'b1;
`else
  localparam logic EXP_LEN_ERR = 1'b0;
`endif

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  function automatic logic [31:0] mk(input logic [2:0] id, input logic [11:0] len);
    return {id, 17'($urandom), len};
  endfunction

  logic [31:0] h, b, b2, t, g, s, x;
  logic [31:0] f;
  logic [31:0] stim[$];
  logic [31:0] expq[$];
  logic [11:0] explen[$];
  logic [2:0]  gid;
  logic [2:0]  pid;
  int          n;
  int          budget;

  initial begin
    rst           = 1'b0;
    bus.in_valid  = 1'b0;
    bus.in_flit   = '0;
    bus.grant     = 1'b0;
    bus.out_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_req", bus.req, 0);
    chk("rst_out_valid", bus.out_valid, 0);
    chk("rst_flit_id", bus.flit_id, 0);
    chk("rst_length", bus.length, 0);
    chk("rst_len_err", bus.len_err, 0);
    rst = 1'b1;
    cyc();
    chk("rst_in_ready", bus.in_ready, 1);

    // Header/body/tail with grant held.
    h = mk(ID_HEAD, 12'd3); b = mk(ID_BODY, 12'($urandom)); t = mk(ID_TAIL, 12'($urandom));
    bus.grant = 1'b1; bus.out_ready = 1'b1;
    bus.in_valid = 1'b1; bus.in_flit = h; cyc();
    bus.in_flit = b; settle();
    chk("p1_idle_req", bus.req, 0);
    cyc();
    bus.in_flit = t; settle();
    chk("p1_req_req", bus.req, 1);
    chk("p1_req_id", bus.flit_id, 32'(ID_HEAD));
    chk("p1_req_ov", bus.out_valid, 0);
    cyc();
    bus.in_valid = 1'b0; settle();
    chk("p1_h_ov", bus.out_valid, 1);
    chk("p1_h_flit", bus.out_flit, h);
    chk("p1_len", bus.length, 3);
    cyc(); settle();
    chk("p1_b_flit", bus.out_flit, b);
    chk("p1_b_ov", bus.out_valid, 1);
    cyc(); settle();
    chk("p1_t_flit", bus.out_flit, t);
    chk("p1_t_id", bus.flit_id, 32'(ID_TAIL));
    chk("p1_t_req", bus.req, 1);
    cyc(); settle();
    chk("p1_end_req", bus.req, 0);
    chk("p1_end_ov", bus.out_valid, 0);
    chk("p1_end_len", bus.length, 3);
    cyc();

    // Grant preemption after the header.
    h = mk(ID_HEAD, 12'd3); b = mk(ID_BODY, 12'($urandom)); t = mk(ID_TAIL, 12'($urandom));
    bus.in_valid = 1'b1; bus.in_flit = h; cyc();
    bus.in_flit = b; cyc();
    bus.in_flit = t; cyc();
    bus.in_valid = 1'b0; settle();
    chk("p2_h_flit", bus.out_flit, h);
    cyc();
    bus.grant = 1'b0; settle();
    chk("p2_drop_ov", bus.out_valid, 0);
    cyc();
    for (int i = 0; i < 4; i++) begin
      bus.grant = (i == 3); settle();
      chk("p2_stall_ov", bus.out_valid, 0);
      chk("p2_stall_req", bus.req, 1);
      chk("p2_stall_id", bus.flit_id, 32'(ID_BODY));
      cyc();
    end
    settle();
    chk("p2_b_flit", bus.out_flit, b);
    chk("p2_b_ov", bus.out_valid, 1);
    cyc(); settle();
    chk("p2_t_flit", bus.out_flit, t);
    chk("p2_t_ov", bus.out_valid, 1);
    cyc(); settle();
    chk("p2_end_req", bus.req, 0);
    cyc();

    // Orphan body flit ahead of a single-flit packet.
    g = mk(ID_BODY, 12'($urandom)); s = mk(ID_SINGLE, 12'd7);
    bus.grant = 1'b0;
    bus.in_valid = 1'b1; bus.in_flit = g; cyc();
    bus.in_flit = s; settle();
    chk("p3_orphan_req", bus.req, 0);
    cyc();
    bus.in_valid = 1'b0; settle();
    chk("p3_disc_req", bus.req, 0);
    chk("p3_disc_head", bus.out_flit, s);
    cyc(); settle();
    chk("p3_req", bus.req, 1);
    chk("p3_len", bus.length, 1);
    bus.grant = 1'b1; cyc(); settle();
    chk("p3_s_ov", bus.out_valid, 1);
    chk("p3_s_flit", bus.out_flit, s);
    chk("p3_s_id", bus.flit_id, 32'(ID_SINGLE));
    cyc(); settle();
    chk("p3_end_req", bus.req, 0);
    chk("p3_end_ov", bus.out_valid, 0);

    // Fill to full, rejected push, one pop.
    h = mk(ID_HEAD, 12'd4); b = mk(ID_BODY, 12'($urandom)); b2 = mk(ID_BODY, 12'($urandom));
    t = mk(ID_TAIL, 12'($urandom)); x = mk(ID_SINGLE, 12'd1);
    bus.grant = 1'b0; bus.out_ready = 1'b0;
    bus.in_valid = 1'b1; bus.in_flit = h; cyc();
    bus.in_flit = b; cyc();
    bus.in_flit = b2; cyc();
    bus.in_flit = t; cyc();
    bus.in_flit = x; settle();
    chk("p4_full", bus.in_ready, 0);
    cyc(); settle();
    chk("p4_full_hold", bus.in_ready, 0);
    bus.in_valid = 1'b0; bus.grant = 1'b1; bus.out_ready = 1'b1; settle();
    chk("p4_req_ov", bus.out_valid, 0);
    cyc(); settle();
    chk("p4_h_flit", bus.out_flit, h);
    chk("p4_h_ov", bus.out_valid, 1);
    chk("p4_h_rdy", bus.in_ready, 0);
    cyc(); settle();
    chk("p4_pop_rdy", bus.in_ready, 1);
    chk("p4_b_flit", bus.out_flit, b);
    cyc(); settle();
    chk("p4_b2_flit", bus.out_flit, b2);
    cyc(); settle();
    chk("p4_t_flit", bus.out_flit, t);
    cyc(); settle();
    chk("p4_end_req", bus.req, 0);
    cyc(); cyc(); settle();
    chk("p4_no_phantom", bus.req, 0);

    // Randomized packet stream with orphan flits between packets.
    for (int p = 0; p < 40; p++) begin
      n = $urandom_range(5, 1);
      if ($urandom_range(3) == 0) begin
        gid = 3'($urandom);
        while (is_start(gid)) gid = 3'($urandom);
        stim.push_back(mk(gid, 12'($urandom)));
      end
      if (n == 1) begin
        f = mk(ID_SINGLE, 12'($urandom));
        stim.push_back(f); expq.push_back(f); explen.push_back(12'd1);
      end else begin
        for (int k = 0; k < n; k++) begin
          pid = (k == 0) ? ID_HEAD : ((k == n - 1) ? ID_TAIL : ID_BODY);
          f = mk(pid, (k == 0) ? 12'(n) : 12'($urandom));
          stim.push_back(f); expq.push_back(f); explen.push_back(12'(n));
        end
      end
    end
    budget = 0;
    while ((stim.size() > 0 || expq.size() > 0) && budget < 6000) begin
      bus.in_valid  = (stim.size() > 0) && ($urandom_range(3) != 0);
      bus.in_flit   = (stim.size() > 0) ? stim[0] : $urandom;
      bus.out_ready = ($urandom_range(3) != 0);
      bus.grant     = ($urandom_range(7) != 0);
      settle();
      if (bus.out_valid && bus.out_ready) begin
        if (expq.size() == 0) begin
          chk("rnd_extra_xfer", 1, 0);
        end else begin
          chk("rnd_flit", bus.out_flit, expq[0]);
          chk("rnd_len", bus.length, 32'(explen[0]));
          chk("rnd_req", bus.req, 1);
          void'(expq.pop_front());
          void'(explen.pop_front());
        end
      end
      if (bus.in_valid && bus.in_ready) void'(stim.pop_front());
      cyc();
      budget++;
    end
    chk("rnd_drain", 32'(expq.size() + stim.size()), 0);
    bus.in_valid = 1'b0; settle();
    chk("rnd_idle_req", bus.req, 0);
    chk("rnd_len_err", bus.len_err, 0);

    // Header claims 3 flits but the tail arrives second.
    h = mk(ID_HEAD, 12'd3); t = mk(ID_TAIL, 12'($urandom));
    bus.grant = 1'b1; bus.out_ready = 1'b1;
    bus.in_valid = 1'b1; bus.in_flit = h; cyc();
    bus.in_flit = t; cyc();
    bus.in_valid = 1'b0; cyc(); settle();
    chk("p5_h_flit", bus.out_flit, h);
    cyc(); settle();
    chk("p5_t_flit", bus.out_flit, t);
    cyc(); settle();
    chk("p5_len_err", bus.len_err, 32'(EXP_LEN_ERR));
    cyc(); cyc(); cyc(); settle();
    chk("p5_len_err_sticky", bus.len_err, 32'(EXP_LEN_ERR));

    // Reset in the middle of SEND.
    h = mk(ID_HEAD, 12'd3); b = mk(ID_BODY, 12'($urandom)); s = mk(ID_SINGLE, 12'($urandom));
    bus.in_valid = 1'b1; bus.in_flit = h; cyc();
    bus.in_flit = b; cyc();
    bus.in_valid = 1'b0; cyc(); settle();
    chk("p6_h_ov", bus.out_valid, 1);
    cyc(); settle();
    chk("p6_b_ov", bus.out_valid, 1);
    rst = 1'b0; #1;
    chk("p6_rst_req", bus.req, 0);
    chk("p6_rst_ov", bus.out_valid, 0);
    chk("p6_rst_id", bus.flit_id, 0);
    chk("p6_rst_len", bus.length, 0);
    chk("p6_rst_len_err", bus.len_err, 0);
    cyc();
    rst = 1'b1; settle();
    chk("p6_rel_rdy", bus.in_ready, 1);
    chk("p6_rel_ov", bus.out_valid, 0);
    bus.in_valid = 1'b1; bus.in_flit = s; cyc();
    bus.in_valid = 1'b0; settle();
    chk("p6_fresh_head", bus.out_flit, s);
    chk("p6_fresh_idle", bus.req, 0);
    cyc(); settle();
    chk("p6_fresh_req", bus.req, 1);
    cyc(); settle();
    chk("p6_fresh_ov", bus.out_valid, 1);
    chk("p6_fresh_flit", bus.out_flit, s);
    cyc(); settle();
    chk("p6_fresh_end", bus.req, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
